qspi_initiator: RTL

- QSPI host (initiator) for the bridge's QSPI target port. Drives SCK, CS and IO0-3 toward the target and runs one transaction segment per request.
- The request interface carries the same fields the target reports on its debug port: mode, direction, bit count, MOSI word and MISO word.
- Used in the FPGA self-test/loopback build and as the host-side engine on the companion board.
- Segments can be chained under one CS assertion, e.g. command, then address, then dummy, then data.

---
 rtl/qspi_initiator.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_initiator.sv
`default_nettype none
// ============================================================================
// Module   : qspi_initiator
// Purpose  : QSPI host engine; runs one SCK/CS/IO segment per request and can
//            chain segments under one CS. Optional abort_i via
//            QSPI_INITIATOR_ABORT_EN.
// Revision : 1.0  initial release
// ============================================================================
module qspi_initiator #(
    parameter int CLK_DIV = 2,
    parameter int DW      = 32
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          txn_valid_i,
    output logic          txn_ready_o,
    input  logic [1:0]    txn_mode_i,
    input  logic          txn_dir_i,
    input  logic [5:0]    txn_bc_i,
    input  logic [DW-1:0] txn_mosi_i,
    input  logic          txn_hold_i,
    output logic [DW-1:0] txn_miso_o,
    output logic          txn_done_o,
`ifdef QSPI_INITIATOR_ABORT_EN
    input  logic          abort_i,
`endif
    output logic          spi_sck_o,
    output logic          spi_sce_o,
    output logic [3:0]    spi_io_o,
    output logic [3:0]    spi_io_oe,
    input  logic [3:0]    spi_io_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4,
        S_CSGAP = 3'd5,
        S_HELD  = 3'd6
    } state_t;

    localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [6:0] C_DW       = 7'(DW);

    state_t        r_state;
    logic [7:0]    r_div;
    logic [6:0]    r_beats;
    logic [1:0]    r_mode;
    logic          r_dir;
    logic          r_hold;
    logic [DW-1:0] r_tx;
    logic [DW-1:0] r_rx;
    logic          r_ready;
    logic          r_done;
    logic [DW-1:0] r_miso;
    logic          r_sck;
    logic          r_sce;
    logic [3:0]    r_io;
    logic [3:0]    r_oe;

    logic [6:0]    w_bc_up;
    logic [6:0]    w_eff;
    logic [6:0]    w_beats;
    logic [DW-1:0] w_tx_align;
    logic [DW-1:0] w_tx_next;
    logic          w_phase_end;
    logic          w_abort;

    // Outgoing bits are kept left-aligned so the current beat is always the MSBs.
    function automatic logic [3:0] lane_bits(input logic [DW-1:0] v, input logic [1:0] mode);
        case (mode)
            2'd1:    lane_bits = {2'b00, v[DW-1 -: 2]};
            2'd2:    lane_bits = v[DW-1 -: 4];
            default: lane_bits = {3'b000, v[DW-1]};
        endcase
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] v, input logic [1:0] mode);
        case (mode)
            2'd1:    shift_out = {v[DW-3:0], 2'b00};
            2'd2:    shift_out = {v[DW-5:0], 4'b0000};
            default: shift_out = {v[DW-2:0], 1'b0};
        endcase
    endfunction

    // Single-lane reads take MISO from IO1; dual/quad take the low lanes.
    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] v, input logic [1:0] mode,
                                               input logic [3:0] io);
        case (mode)
            2'd1:    shift_in = {v[DW-3:0], io[1:0]};
            2'd2:    shift_in = {v[DW-5:0], io};
            default: shift_in = {v[DW-2:0], io[1]};
        endcase
    endfunction

    function automatic logic [3:0] oe_mask(input logic [1:0] mode);
        case (mode)
            2'd1:    oe_mask = 4'b0011;
            2'd2:    oe_mask = 4'b1111;
            default: oe_mask = 4'b0001;
        endcase
    endfunction

    always_comb begin
        case (txn_mode_i)
            2'd1: begin
                w_bc_up = ({1'b0, txn_bc_i} + 7'd1) & 7'b1111110;
                w_beats = '0;
            end
            2'd2: begin
                w_bc_up = ({1'b0, txn_bc_i} + 7'd3) & 7'b1111100;
                w_beats = '0;
            end
            default: begin
                w_bc_up = {1'b0, txn_bc_i};
                w_beats = '0;
            end
        endcase
        w_eff = (w_bc_up > C_DW) ? C_DW : w_bc_up;
        case (txn_mode_i)
            2'd1:    w_beats = w_eff >> 1;
            2'd2:    w_beats = w_eff >> 2;
            default: w_beats = w_eff;
        endcase
        w_tx_align  = txn_mosi_i << (C_DW - w_eff);
        w_tx_next   = shift_out(r_tx, r_mode);
        w_phase_end = (r_div == C_DIV_LAST);
`ifdef QSPI_INITIATOR_ABORT_EN
        // CSGAP is already the abort landing state; re-entering it would double the done pulse.
        w_abort = abort_i && (r_state != S_IDLE) && (r_state != S_CSGAP);
`else
        w_abort = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_beats <= '0;
            r_mode  <= '0;
            r_dir   <= 1'b0;
            r_hold  <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_miso  <= '0;
            r_sck   <= 1'b0;
            r_sce   <= 1'b1;
            r_io    <= '0;
            r_oe    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= S_CSGAP;
                r_div   <= '0;
                r_sck   <= 1'b0;
                r_oe    <= '0;
                r_sce   <= 1'b1;
                r_done  <= 1'b1;
                r_miso  <= '0;
                r_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_HELD: begin
                        if (!r_ready) begin
                            r_ready <= 1'b1;
                        end else if (txn_valid_i) begin
                            r_ready <= 1'b0;
                            r_mode  <= txn_mode_i;
                            r_dir   <= txn_dir_i;
                            r_hold  <= txn_hold_i;
                            if (w_eff == 7'd0) begin
                                // Empty segment: no clocks, CS left as it is.
                                r_done <= 1'b1;
                                r_miso <= '0;
                            end else begin
                                r_state <= S_SETUP;
                                r_div   <= '0;
                                r_sce   <= 1'b0;
                                r_beats <= w_beats;
                                r_tx    <= w_tx_align;
                                r_rx    <= '0;
                                if (txn_dir_i) begin
                                    r_io <= lane_bits(w_tx_align, txn_mode_i);
                                    r_oe <= oe_mask(txn_mode_i);
                                end else begin
                                    r_oe <= '0;
                                end
                            end
                        end
                    end
                    S_SETUP: begin
                        if (w_phase_end) begin
                            r_state <= S_HIGH;
                            r_div   <= '0;
                            r_sck   <= 1'b1;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    S_HIGH: begin
                        if (w_phase_end) begin
                            if (!r_dir) begin
                                r_rx <= shift_in(r_rx, r_mode, spi_io_i);
                            end else begin
                                r_io <= lane_bits(w_tx_next, r_mode);
                            end
                            r_tx    <= w_tx_next;
                            r_beats <= r_beats - 7'd1;
                            r_state <= S_LOW;
                            r_div   <= '0;
                            r_sck   <= 1'b0;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    S_LOW: begin
                        if (w_phase_end) begin
                            r_div <= '0;
                            if (r_beats != 7'd0) begin
                                r_state <= S_HIGH;
                                r_sck   <= 1'b1;
                            end else if (r_hold) begin
                                r_state <= S_HELD;
                                r_done  <= 1'b1;
                                r_ready <= 1'b1;
                                r_miso  <= r_dir ? '0 : r_rx;
                            end else begin
                                r_state <= S_HOLD;
                            end
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    S_HOLD: begin
                        if (w_phase_end) begin
                            r_state <= S_CSGAP;
                            r_div   <= '0;
                            r_sce   <= 1'b1;
                            r_oe    <= '0;
                            r_done  <= 1'b1;
                            r_miso  <= r_dir ? '0 : r_rx;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    S_CSGAP: begin
                        if (w_phase_end) begin
                            r_state <= S_IDLE;
                            r_div   <= '0;
                            r_ready <= 1'b1;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_sce   <= 1'b1;
                        r_sck   <= 1'b0;
                        r_oe    <= '0;
                    end
                endcase
            end
        end
    end

    assign txn_ready_o = r_ready;
    assign txn_done_o  = r_done;
    assign txn_miso_o  = r_miso;
    assign spi_sck_o   = r_sck;
    assign spi_sce_o   = r_sce;
    assign spi_io_o    = r_io;
    assign spi_io_oe   = r_oe;

endmodule
`default_nettype wire
